// File: rtl/ifid_stage_reg_if.sv
// ifid_stage_reg_if
// Purpose : bundles the fetch-side and decode-side handshake/bus signals of
//           the IF/ID pipeline register into one interface.
// Signals :
//   in_valid / in_ready / in_instr / in_pc      fetch-side valid/ready channel
//   flush                                       discard held and incoming words
//   out_valid / out_ready / out_instr / out_pc  decode-side valid/ready channel
//   out_opcode                                  out_instr[IW-1:IW-6]
//   out_imm                                     out_instr[IMMW-1:0], to sign extender
// Modports:
//   slave  : the pipeline register itself
//   master : the surrounding environment (fetch, decode, branch unit)
interface ifid_stage_reg_if #(
  parameter int IW   = 32,
  parameter int PCW  = 32,
  parameter int IMMW = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [IW-1:0]   in_instr;
  logic [PCW-1:0]  in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [IW-1:0]   out_instr;
  logic [PCW-1:0]  out_pc;
  logic [5:0]      out_opcode;
  logic [IMMW-1:0] out_imm;

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_opcode, out_imm
  );

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_opcode, out_imm
  );
endinterface

// File: rtl/ifid_stage_reg.sv
// ifid_stage_reg
// Purpose : IF/ID pipeline register with a two-entry skid buffer. The main
//           entry drives the decode side; the skid entry absorbs one extra
//           word when decode stalls so that in_ready can be a flop.
// Ports   :
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset (state -> EMPTY, data -> 0)
//   bus    ifid_stage_reg_if.slave, fetch and decode handshakes plus flush
// Parameters: IW instruction width, PCW PC width, IMMW immediate width
//             (IMMW must not exceed IW-6).
module ifid_stage_reg #(
  parameter int IW   = 32,
  parameter int PCW  = 32,
  parameter int IMMW = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  ifid_stage_reg_if.slave    bus
);

  // Encoding chosen so bit 0 is the main-entry valid and bit 1 the skid valid.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic           r_in_ready;
  logic [IW-1:0]  r_main_instr;
  logic [PCW-1:0] r_main_pc;
  logic [IW-1:0]  r_skid_instr;
  logic [PCW-1:0] r_skid_pc;

  logic w_acc;
  logic w_rel;
  logic w_load_main;
  logic w_load_skid;
  logic w_move_skid;

  assign w_acc = bus.in_valid & r_in_ready;
  assign w_rel = r_state[0] & bus.out_ready;

  // Next-state and datapath steering. Flush overrides everything: held and
  // incoming words are dropped, a release on the same edge is simply lost
  // with the rest since decode has already taken it.
  always_comb begin
    w_next_state = r_state;
    w_load_main  = 1'b0;
    w_load_skid  = 1'b0;
    w_move_skid  = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_acc) begin
          w_next_state = ONE;
          w_load_main  = 1'b1;
        end
      end
      ONE: begin
        if (w_acc && w_rel) begin
          w_load_main = 1'b1;
        end else if (w_acc) begin
          w_next_state = TWO;
          w_load_skid  = 1'b1;
        end else if (w_rel) begin
          w_next_state = EMPTY;
        end
      end
      TWO: begin
        if (w_rel) begin
          w_next_state = ONE;
          w_move_skid  = 1'b1;
        end
      end
      default: begin
        w_next_state = EMPTY;
      end
    endcase
    if (bus.flush) begin
      w_next_state = EMPTY;
      w_load_main  = 1'b0;
      w_load_skid  = 1'b0;
      w_move_skid  = 1'b0;
    end
  end

  // in_ready is registered: it is computed from the next state so it is
  // already low in the cycle after entering TWO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state != TWO);
    end
  end

  // Data entries are only written when a word moves; flush leaves them alone
  // so the outputs keep their last value while out_valid is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_main_instr <= '0;
      r_main_pc    <= '0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
    end else begin
      if (w_load_main) begin
        r_main_instr <= bus.in_instr;
        r_main_pc    <= bus.in_pc;
      end else if (w_move_skid) begin
        r_main_instr <= r_skid_instr;
        r_main_pc    <= r_skid_pc;
      end
      if (w_load_skid) begin
        r_skid_instr <= bus.in_instr;
        r_skid_pc    <= bus.in_pc;
      end
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_state[0];
  assign bus.out_instr  = r_main_instr;
  assign bus.out_pc     = r_main_pc;
  assign bus.out_opcode = r_main_instr[IW-1:IW-6];
  assign bus.out_imm    = r_main_instr[IMMW-1:0];

endmodule
